ram_sync_param: RTL and testbench

Parametrised single-port synchronous RAM with a clocked read/write interface, a registered read path with a valid strobe, and an automatic post-reset clear sequencer. It is the clocked successor to the 32×8 asynchronous tri-state RAM: width and depth are generics, and the bidirectional IO bus is split into DIN/DOUT. It sits as a local scratch/storage buffer behind a simple master that drives chip-select, read/write select and address every cycle.

---
 rtl/ram_sync_param.sv | 94 +++++++++
 tb/tb_ram_sync_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read, valid strobe,
// sticky out-of-range flag and an automatic clear sweep after every reset.
module ram_sync_param #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 5,
  parameter int                 DEPTH   = 32,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CS,
  input  logic              RWS,
  input  logic              W_EN,
  input  logic [ADDR_W-1:0] W_S,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  output logic              READY,
  output logic              ERR
);

  localparam int                CNT_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [CNT_W-1:0]  acc_idx;
  logic [CNT_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  // W_S below DEPTH always fits in CNT_W bits, so truncation is safe once in range.
  assign in_range = ({1'b0, W_S} < DEPTH_L);
  assign acc_idx  = W_S[CNT_W-1:0];
  assign wr_acc   = READY & CS & RWS & W_EN;
  assign rd_acc   = READY & CS & ~RWS;

  // The clear sweep and normal writes share the single write port.
  assign wr_en    = ~READY | (wr_acc & in_range);
  assign wr_idx   = READY ? acc_idx : clr_cnt;
  assign wr_data  = READY ? DIN : CLR_VAL;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      READY   <= 1'b0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          DVALID <= 1'b0;
          if (clr_cnt == LAST) begin
            state   <= IDLE;
            READY   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          DVALID <= rd_acc;
          if (rd_acc) begin
            DOUT <= in_range ? mem[acc_idx] : CLR_VAL;
          end
          if ((wr_acc | rd_acc) & ~in_range) begin
            ERR <= 1'b1;
          end
        end
        default: begin
          state  <= CLEAR;
          DVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboard bench: two RAM instances (32 words and 20 words) share one stimulus
// stream; a reference model predicts reads, READY and ERR for each.
module tb_ram_sync_param;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cs = 1'b0;
  logic            rws = 1'b0;
  logic            wen = 1'b0;
  logic [4:0]      addr = '0;
  logic [7:0]      din = '0;
  logic [1:0][7:0] dout;
  logic [1:0]      dvalid;
  logic [1:0]      ready;
  logic [1:0]      err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_sync_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .CLR_VAL(8'hA5)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CS(cs), .RWS(rws), .W_EN(wen), .W_S(addr), .DIN(din),
    .DOUT(dout[0]), .DVALID(dvalid[0]), .READY(ready[0]), .ERR(err[0])
  );

  ram_sync_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .CLR_VAL(8'h66)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CS(cs), .RWS(rws), .W_EN(wen), .W_S(addr), .DIN(din),
    .DOUT(dout[1]), .DVALID(dvalid[1]), .READY(ready[1]), .ERR(err[1])
  );

  // Reference model state
  logic [7:0] mref [2][32];
  bit         rdy  [2];
  bit         errm [2];
  bit         pend [2];
  int         cnt  [2];
  logic [7:0] dlast[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic int depth_of(int id);
    return (id == 0) ? 32 : 20;
  endfunction

  function automatic logic [7:0] clr_of(int id);
    return (id == 0) ? 8'hA5 : 8'h66;
  endfunction

  task automatic check(string name, int id, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, id, act, exp, $time);
    end
  endtask

  task automatic qpush(int id, logic [7:0] v);
    if (id == 0) q0.push_back(v);
    else         q1.push_back(v);
  endtask

  task automatic qpop(int id, output logic [7:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    if (id == 0 && q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
    if (id == 1 && q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
  endtask

  function automatic int qsize(int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int id = 0; id < 2; id++) begin
      rdy[id]   = 1'b0;
      errm[id]  = 1'b0;
      pend[id]  = 1'b0;
      cnt[id]   = 0;
      dlast[id] = 8'h00;
      // After the sweep every implemented word holds the clear value.
      for (int k = 0; k < 32; k++) mref[id][k] = clr_of(id);
    end
  endtask

  // Apply what the DUTs saw at the rising edge that just happened.
  task automatic model_step();
    if (!rst_n) return;
    for (int id = 0; id < 2; id++) begin
      pend[id] = 1'b0;
      if (!rdy[id]) begin
        cnt[id]++;
        if (cnt[id] == depth_of(id)) rdy[id] = 1'b1;
      end else if (cs && rws && wen) begin
        if (int'(addr) < depth_of(id)) mref[id][addr] = din;
        else                           errm[id] = 1'b1;
      end else if (cs && !rws) begin
        pend[id] = 1'b1;
        if (int'(addr) < depth_of(id)) qpush(id, mref[id][addr]);
        else begin
          qpush(id, clr_of(id));
          errm[id] = 1'b1;
        end
      end
    end
  endtask

  task automatic access(logic c, logic r, logic w, logic [4:0] a, logic [7:0] d);
    cs = c; rws = r; wen = w; addr = a; din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rnd_access();
    logic c, r, w;
    logic [4:0] a;
    c = ($urandom % 4) != 0;
    r = $urandom % 2;
    w = ($urandom % 4) != 0;
    a = 5'($urandom % 32);
    // Keep disabled writes in range: their effect on the error flag is left open.
    if (c && r && !w && a >= 5'd20) a = 5'(a % 20);
    access(c, r, w, a, 8'($urandom_range(255)));
  endtask

  task automatic direct_reset_check();
    for (int id = 0; id < 2; id++) begin
      check("rst_dout",   id, dout[id], 8'h00);
      check("rst_dvalid", id, 8'(dvalid[id]), 8'h00);
      check("rst_ready",  id, 8'(ready[id]), 8'h00);
      check("rst_err",    id, 8'(err[id]), 8'h00);
    end
  endtask

  // Assert reset between edges and confirm the outputs drop without a clock.
  task automatic assert_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    direct_reset_check();
  endtask

  task automatic release_reset();
    #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [7:0] exp;
    bit ok;
    for (int id = 0; id < 2; id++) begin
      check("ready",  id, 8'(ready[id]), 8'(rdy[id]));
      check("err",    id, 8'(err[id]), 8'(errm[id]));
      check("dvalid", id, 8'(dvalid[id]), 8'(pend[id]));
      if (dvalid[id]) begin
        qpop(id, exp, ok);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read dut%0d: got dout %h with no read outstanding at %0t",
                   id, dout[id], $time);
        end else begin
          check("rd_data", id, dout[id], exp);
          dlast[id] = exp;
        end
      end else begin
        check("dout_hold", id, dout[id], dlast[id]);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) access(0, 0, 0, 0, 0);
    direct_reset_check();
    release_reset();

    // Clear sweep with traffic that must be ignored until READY.
    repeat (32) rnd_access();

    for (int i = 0; i < 32; i++) access(1, 0, 0, 5'(i), 0);
    for (int i = 0; i < 20; i++) access(1, 1, 1, 5'(i), 8'($urandom_range(255)));
    for (int i = 0; i < 32; i++) access(1, 0, 0, 5'(i), 0);

    // Write-enable and chip-select gating
    access(1, 1, 1, 5'd7, 8'h3C);
    access(1, 1, 0, 5'd7, 8'hFF);
    access(0, 1, 1, 5'd7, 8'hFF);
    access(1, 0, 0, 5'd7, 0);

    // Read-after-write and back-to-back reads
    access(1, 1, 1, 5'd3, 8'h5A);
    access(1, 0, 0, 5'd3, 0);
    access(1, 0, 0, 5'd3, 0);
    access(1, 0, 1, 5'd4, 0);
    access(0, 0, 0, 0, 0);

    // Out of range on the 20-word instance
    access(1, 1, 1, 5'd25, 8'h77);
    access(0, 0, 0, 0, 0);
    access(1, 0, 0, 5'd25, 0);
    for (int i = 0; i < 32; i++) access(1, 0, 0, 5'(i), 0);

    repeat (400) rnd_access();

    // Reset in the middle of a read, then again in the middle of the sweep.
    access(1, 0, 0, 5'd5, 0);
    assert_reset();
    repeat (2) access(1, 0, 0, 5'd1, 0);
    release_reset();
    repeat (10) access(0, 0, 0, 0, 0);
    assert_reset();
    repeat (2) access(1, 1, 1, 5'd2, 8'h11);
    release_reset();
    repeat (32) rnd_access();
    for (int i = 0; i < 32; i++) access(1, 0, 0, 5'(i), 0);
    repeat (100) rnd_access();
    repeat (2) access(0, 0, 0, 0, 0);

    for (int id = 0; id < 2; id++) check("reads_outstanding", id, 8'(qsize(id)), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
